// File: rtl/rvga_types.sv
// Shared pipeline types: the control word passed between stages and the
// memory-operation enums it carries.
package rvga_types;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_LOAD  = 2'd1,
    MEM_STORE = 2'd2
  } mem_op_e;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2
  } mem_size_e;

  typedef struct packed {
    logic            valid;
    mem_op_e         mem_op;
    mem_size_e       mem_size;
    logic            mem_unsigned;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] rd_data;
    logic            exc_misaligned;
  } rvga_cword;

  function automatic logic is_misaligned(mem_size_e size, logic [1:0] addr_lo);
    return ((size == SIZE_H) && addr_lo[0]) || ((size == SIZE_W) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering for the data bus: store byte enables and replicated
// store data, plus load extraction with sign/zero extension.
module mem_align
  import rvga_types::*;
(
  input  logic [1:0]      addr_lo,
  input  mem_size_e       size,
  input  logic            is_unsigned,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] rdata,
  output logic [3:0]      be,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_data
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    // NOTE: every output gets a default before the case so no path can leave one unassigned and infer a latch.
    be        = 4'hF;
    wdata     = rs2_data;
    load_data = rdata;
    shifted   = rdata >> {addr_lo, 3'b000};
    case (size)
      SIZE_B: begin
        be        = 4'b0001 << addr_lo;
        wdata     = {4{rs2_data[7:0]}};
        load_data = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
      end
      SIZE_H: begin
        be        = 4'b0011 << addr_lo;
        wdata     = {2{rs2_data[15:0]}};
        load_data = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/memory.sv
// Memory-access stage: runs loads/stores over a req/gnt/rvalid bus and
// stalls upstream while a transaction is in flight.
module memory
  import rvga_types::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_in,
  input  rvga_cword       ex_mem_cword,
  output rvga_cword       mem_wb_cword,
  output logic            stall_out,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_gnt,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_e;

  state_e          state, state_next;
  rvga_cword       hold;
  logic            in_mem, in_misaligned, accept;
  logic [3:0]      be;
  logic [XLEN-1:0] wdata, load_data;

  assign in_mem        = ex_mem_cword.valid && (ex_mem_cword.mem_op != MEM_NONE);
  assign in_misaligned = in_mem && is_misaligned(ex_mem_cword.mem_size, ex_mem_cword.alu_result[1:0]);
  assign accept        = in_mem && !in_misaligned;
  assign stall_out     = (state != IDLE) || accept;

  mem_align u_align (
    .addr_lo     (hold.alu_result[1:0]),
    .size        (hold.mem_size),
    .is_unsigned (hold.mem_unsigned),
    .rs2_data    (hold.rs2_data),
    .rdata       (dmem_rdata),
    .be          (be),
    .wdata       (wdata),
    .load_data   (load_data)
  );

  // Bus signals are gated by REQ so they read zero whenever no request is up.
  assign dmem_req   = (state == REQ);
  assign dmem_we    = dmem_req && (hold.mem_op == MEM_STORE);
  assign dmem_addr  = dmem_req ? {hold.alu_result[XLEN-1:2], 2'b00} : '0;
  assign dmem_be    = dmem_req ? be : 4'h0;
  assign dmem_wdata = dmem_req ? wdata : '0;

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (!stall_in && accept) state_next = REQ;
      REQ:  if (dmem_gnt) state_next = (hold.mem_op == MEM_STORE) ? DONE : RESP;
      RESP: if (dmem_rvalid) state_next = DONE;
      DONE: if (!stall_in) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      hold         <= '0;
      mem_wb_cword <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (!stall_in) begin
            if (accept) begin
              hold         <= ex_mem_cword;
              mem_wb_cword <= '0;
            end else begin
              mem_wb_cword                <= ex_mem_cword;
              mem_wb_cword.exc_misaligned <= ex_mem_cword.exc_misaligned | in_misaligned;
            end
          end
        end
        RESP: if (dmem_rvalid) hold.rd_data <= load_data;
        DONE: if (!stall_in) mem_wb_cword <= hold;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/memory.md
# memory

Pipeline memory-access stage between execute and writeback. Consumes the execute control word (rvga_cword), performs data-memory loads and stores over a req/gnt/rvalid bus, and produces the control word registered into writeback. Load data is aligned and sign/zero-extended into the word's rd_data field. The stage stalls the upstream pipeline while a bus transaction is outstanding.

## Interface
- XLEN, 32, data/address width (from rvga_params.vh)
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- stall_in  in  1  global pipeline freeze from hazard/control logic
- ex_mem_cword  in  rvga_cword  control word from execute
- mem_wb_cword  out  rvga_cword  control word to writeback
- stall_out  out  1  stage busy; upstream must hold ex_mem_cword
- dmem_req  out  1  bus request
- dmem_we  out  1  1 = store
- dmem_addr  out  XLEN  word-aligned address (alu_result with low 2 bits cleared)
- dmem_be  out  4  byte enables
- dmem_wdata  out  XLEN  store data, lane-shifted
- dmem_gnt  in  1  request accepted this cycle
- dmem_rvalid  in  1  load data valid
- dmem_rdata  in  XLEN  load data

## Operation
- rvga_cword fields used: valid, mem_op (NONE/LOAD/STORE), mem_size (B/H/W), mem_unsigned, alu_result (address), rs2_data, rd_data, exc_misaligned.
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE, stall_in=0, input valid with mem_op=NONE: register the word unchanged into mem_wb_cword.
- IDLE, stall_in=0, input valid LOAD/STORE, aligned: latch the word into the hold register, go to REQ, and drive mem_wb_cword as a bubble (valid=0).
- Misaligned means H with addr[0]=1, or W with addr[1:0]!=0. It issues no bus access; the word is passed through with exc_misaligned=1 in one cycle.
- REQ: dmem_req=1; the address, be, wdata and we fields stay stable until dmem_gnt. On gnt, a STORE goes to DONE and a LOAD goes to RESP.
- RESP: wait for dmem_rvalid. Capture the extended data into hold.rd_data, then go to DONE.
- DONE: if stall_in=0, emit the hold word on mem_wb_cword and return to IDLE. Otherwise stay in DONE, with mem_wb_cword holding its last value.
- Byte enables are B: 1<<a[1:0], H: 3<<a[1:0], W: 4'hF. Store data is rs2_data replicated across byte/half lanes.
- Load extraction: byte/half selected by a[1:0], sign-extended unless mem_unsigned=1.
- stall_out = (state != IDLE) OR (state == IDLE AND input is a valid aligned mem op).
- stall_in is asserted in REQ or RESP: the bus transaction continues to completion and the result is parked in DONE.
- stall_in in IDLE: no acceptance, and mem_wb_cword holds.
- dmem_rvalid arriving outside RESP is ignored.

## Timing
- Reset (asynchronous): state=IDLE, and every output is 0, i.e. mem_wb_cword=0 (valid=0), dmem_req/we/be/addr/wdata=0, stall_out=0.
- If reset is asserted mid-transaction, the transaction is abandoned. There is no bus handshake on reset; the interconnect is reset by the same rst_n.
- Non-memory and misaligned words: 1-cycle latency.
- Store with gnt on the first REQ cycle: accept edge, then REQ, then DONE, then output. The result appears 3 edges after accept.
- Load with gnt on the first REQ cycle and rvalid on the next cycle: the result appears 4 edges after accept.
- Each extra gnt or rvalid wait cycle adds 1 to the latency.
- stall_out is combinational from state and ex_mem_cword. dmem_* outputs are combinational from state and the hold register.

## Structure
- rvga_types (shared package) holds the rvga_cword fields listed above, plus the mem_op_e and mem_size_e enums.
- The FSM state enum is local to the block.
- One sub-module, mem_align: purely combinational. It takes addr[1:0], size, unsigned, rs2_data and rdata, and produces be, wdata and load_data. It is unit-tested separately.

## Test plan
- ALU word (mem_op=NONE, rd_data=0x1234), stall_in=0 -> emitted next edge unchanged, stall_out never high.
- SW addr=0x100, rs2=0xDEADBEEF, gnt delayed 2 cycles -> dmem_req held 3 cycles, be=F, wdata=0xDEADBEEF; word out 5 edges after accept; stall_out high throughout.
- LB addr=0x103, rdata=0x80FF_FF00 -> rd_data=0xFFFFFF80. Same word with LBU -> 0x00000080.
- LH addr=0x101 -> no dmem_req; exc_misaligned=1 next edge.
- LW with stall_in asserted during RESP, rvalid arrives, stall_in held 3 more cycles -> FSM parks in DONE, rdata captured once, word emitted the edge after stall_in falls.
- rst_n pulsed low while in RESP -> dmem_req=0, mem_wb_cword.valid=0, stall_out=0 immediately; the next input is accepted normally.
